// File: rtl/nios_system_pio_in_edge_if.sv
// nios_system_pio_in_edge_if: Avalon-MM s1 slave bus plus interrupt line
interface nios_system_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_system_pio_in_edge.sv
// nios_system_pio_in_edge: synchronised input PIO with edge capture, irq mask and level/edge irq
module nios_system_pio_in_edge #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_port,
  nios_system_pio_in_edge_if.slave  s1
);
  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] data, prev, edge_q, mask, cap, det, clr_bits;
  logic [2:0] warm;
  logic wr;
  logic [31:0] rd_next;
  assign data = sync[SYNC_STAGES-1];
  assign wr = s1.chipselect & ~s1.write_n;
  assign s1.irq = (IRQ_MODE == 1) ? |(data & mask) : |(cap & mask);
  always_comb begin
    det = (EDGE_TYPE == 0) ? (data & ~prev) : (EDGE_TYPE == 1) ? (~data & prev) : (data ^ prev);
    clr_bits = (wr && s1.address == 2'd3) ? s1.writedata[WIDTH-1:0] : '0;
    rd_next = (s1.address == 2'd0) ? 32'(data) :
              (s1.address == 2'd2) ? 32'(mask) :
              (s1.address == 2'd3) ? 32'(cap) : '0;
  end
  // edge is registered once before capture; warm-up masks the reset-to-input transient
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
      prev <= RESET_VALUE;
      warm <= '0;
      edge_q <= '0;
      cap <= '0;
      mask <= '0;
      s1.readdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_port};
      prev <= data;
      warm <= (warm == WARM) ? warm : warm + 3'd1;
      edge_q <= (warm == WARM) ? det : '0;
      cap <= edge_q | (cap & ~clr_bits);
      if (wr && s1.address == 2'd2) mask <= s1.writedata[WIDTH-1:0];
      s1.readdata <= rd_next;
    end
  end
endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// tb_nios_system_pio_in_edge: scoreboard bench for rising, any-edge and level-irq PIO variants
module tb_nios_system_pio_in_edge;
  logic clk = 0, reset_n = 0;
  logic [7:0] in0 = 0, in1 = 0, in2 = 0;
  int checks = 0, errors = 0;
  logic rd_go = 0;
  typedef struct { int sel; string tag; logic [31:0] exp; } exp_t;
  exp_t q[$];
  nios_system_pio_in_edge_if b0 ();
  nios_system_pio_in_edge_if b1 ();
  nios_system_pio_in_edge_if b2 ();
  nios_system_pio_in_edge #(.WIDTH(8)) dut0 (.clk(clk), .reset_n(reset_n), .in_port(in0), .s1(b0.slave));
  nios_system_pio_in_edge #(.WIDTH(8), .IRQ_MODE(1)) dut1 (.clk(clk), .reset_n(reset_n), .in_port(in1), .s1(b1.slave));
  nios_system_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (.clk(clk), .reset_n(reset_n), .in_port(in2), .s1(b2.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] rdata(input int s);
    return s == 0 ? b0.readdata : s == 1 ? b1.readdata : b2.readdata;
  endfunction
  task automatic bus(input int s, input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    if (s == 0) begin b0.chipselect = cs; b0.write_n = wn; b0.address = a; b0.writedata = d; end
    else if (s == 1) begin b1.chipselect = cs; b1.write_n = wn; b1.address = a; b1.writedata = d; end
    else begin b2.chipselect = cs; b2.write_n = wn; b2.address = a; b2.writedata = d; end
  endtask
  task automatic wr(input int s, input logic [1:0] a, input logic [31:0] d);
    bus(s, 1'b1, 1'b0, a, d);
    @(negedge clk);
    bus(s, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask
  task automatic rd(input int s, input logic [1:0] a, input logic [31:0] e, input string tag);
    bus(s, 1'b1, 1'b1, a, 32'h0);
    q.push_back('{s, tag, e});
    rd_go = 1;
    @(negedge clk);
    rd_go = 0;
    bus(s, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask
  always @(posedge clk) begin
    if (rd_go) begin
      exp_t e;
      #1;
      if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check(e.tag, rdata(e.sel), e.exp);
      end
    end
  end
  initial begin
    for (int s = 0; s < 3; s++) bus(s, 1'b0, 1'b1, 2'd0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_rdata", b0.readdata, 0);
    check("rst_irq", {31'd0, b0.irq}, 0);
    reset_n = 1;
    repeat (6) @(negedge clk);
    // rising edge latency: capture lands on the third edge after sampling
    in0 = 8'h05;
    for (int i = 0; i < 4; i++) rd(0, 2'd3, 32'h0, "cap_latency_pre");
    rd(0, 2'd3, 32'h05, "cap_latency_set");
    rd(0, 2'd0, 32'h05, "data");
    rd(0, 2'd1, 32'h0, "reserved");
    rd(0, 2'd2, 32'h0, "mask_rst");
    check("irq_masked", {31'd0, b0.irq}, 0);
    wr(0, 2'd0, 32'hFF);
    rd(0, 2'd0, 32'h05, "data_ro");
    wr(0, 2'd2, 32'h04);
    check("irq_unmask", {31'd0, b0.irq}, 1);
    wr(0, 2'd3, 32'h01);
    rd(0, 2'd3, 32'h04, "cap_clr_b0");
    check("irq_hold", {31'd0, b0.irq}, 1);
    wr(0, 2'd3, 32'h04);
    check("irq_clr", {31'd0, b0.irq}, 0);
    rd(0, 2'd3, 32'h0, "cap_clr_all");
    in0 = 8'h01;
    repeat (5) @(negedge clk);
    rd(0, 2'd3, 32'h0, "fall_ignored");
    in0 = 8'h05;
    repeat (5) @(negedge clk);
    in0 = 8'h01;
    repeat (5) @(negedge clk);
    rd(0, 2'd3, 32'h04, "cap_b2");
    in0 = 8'h05;
    repeat (3) @(negedge clk);
    wr(0, 2'd3, 32'h04);
    rd(0, 2'd3, 32'h04, "set_wins");
    check("irq_set_wins", {31'd0, b0.irq}, 1);
    // any-edge variant: a pulse captures once, each edge alone sets the bit
    in2 = 8'h80;
    repeat (5) @(negedge clk);
    in2 = 8'h00;
    repeat (6) @(negedge clk);
    rd(2, 2'd3, 32'h80, "any_pulse");
    wr(2, 2'd3, 32'h80);
    rd(2, 2'd3, 32'h0, "any_clr");
    in2 = 8'h80;
    repeat (6) @(negedge clk);
    rd(2, 2'd3, 32'h80, "any_rise");
    wr(2, 2'd3, 32'h80);
    in2 = 8'h00;
    repeat (6) @(negedge clk);
    rd(2, 2'd3, 32'h80, "any_fall");
    // level irq variant
    wr(1, 2'd2, 32'h01);
    in1 = 8'h01;
    @(negedge clk);
    check("lvl_irq_lat", {31'd0, b1.irq}, 0);
    @(negedge clk);
    check("lvl_irq_hi", {31'd0, b1.irq}, 1);
    in1 = 8'h00;
    repeat (4) @(negedge clk);
    check("lvl_irq_lo", {31'd0, b1.irq}, 0);
    rd(1, 2'd1, 32'h0, "lvl_reserved");
    rd(1, 2'd3, 32'h01, "lvl_cap");
    // async reset while irq pending, then warm-up against a static input
    rd(0, 2'd2, 32'h04, "mask_pre_rst");
    #2 reset_n = 0;
    #1;
    check("arst_irq", {31'd0, b0.irq}, 0);
    check("arst_rdata", b0.readdata, 0);
    in0 = 8'hFF;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (8) @(negedge clk);
    rd(0, 2'd3, 32'h0, "warm_cap");
    rd(0, 2'd2, 32'h0, "warm_mask");
    rd(0, 2'd0, 32'hFF, "warm_data");
    check("warm_irq", {31'd0, b0.irq}, 0);
    repeat (2) @(negedge clk);
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
